// File: rtl/aer_pkg.sv
// Shared types and constants for the AER transmit link.
// Optional ACK watchdog is enabled by defining AER_TX_TIMEOUT_EN.
package aer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        REQ_HI = 2'd2,
        REQ_LO = 2'd3
    } aer_tx_state_t;

    localparam int AER_ADDR_W = 10;
    localparam logic [AER_ADDR_W-1:0] AER_RST_WORD = 10'h1FF;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchroniser for an asynchronous input.
// Async active-low reset clears every stage.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] q_q;

    generate
        if (STAGES < 2) begin : g_bad
            $error("sync_ff needs at least two stages");
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= {q_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = q_q[STAGES-1];

endmodule

// File: rtl/aer_tx_link.sv
// Captures encoder indices and sends them over a 4-phase AER REQ/ACK link.
// Define AER_TX_TIMEOUT_EN to add the ACK watchdog and TIMEOUT_ERR flag.
import aer_pkg::*;

module aer_tx_link #(
    parameter int AER_W          = AER_ADDR_W,
    parameter int SYNC_STAGES    = 2,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [AER_W-1:0] IDX_IN,
    input  logic             IDX_VALID,
    output logic [AER_W-1:0] AERIN_ADDR,
    output logic             AERIN_REQ,
    input  logic             AERIN_ACK,
    output logic             AERIN_CTRL_BUSY,
    output logic [CNT_W-1:0] EVT_SENT_CNT,
    output logic             OVERRUN,
    output logic             TIMEOUT_ERR
);

    generate
        if (TIMEOUT_CYCLES < 1) begin : g_bad_to
            $error("TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    aer_tx_state_t    state_q, state_d;
    logic [AER_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q;
    logic             req_q, req_d;
    logic             busy_q, busy_d;
    logic             ovr_q, ovr_d;
    logic             ack_s;
    logic             cap;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk  (CLK),
        .rst_n(RST_N),
        .d_i  (AERIN_ACK),
        .q_o  (ack_s)
    );

    assign cap = IDX_VALID & ~valid_q;

`ifdef AER_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            to_q, to_d;
    logic            in_hs;
    logic            wd_hit;

    assign in_hs  = (state_q == REQ_HI) || (state_q == REQ_LO);
    assign wd_hit = in_hs && (wd_q == WD_LAST);
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q | (cap & (state_q != IDLE));
        unique case (state_q)
            IDLE: begin
                if (cap) begin
                    addr_d  = IDX_IN;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                // ACK may still be high from the previous transfer
                if (!ack_s) state_d = REQ_HI;
            end
            REQ_HI: begin
                if (ack_s) state_d = REQ_LO;
            end
            REQ_LO: begin
                if (!ack_s) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef AER_TX_TIMEOUT_EN
        to_d = to_q;
        if (wd_hit) begin
            state_d = IDLE;
            cnt_d   = cnt_q;
            to_d    = 1'b1;
        end
        if (state_d != state_q) begin
            wd_d = '0;
        end else if (in_hs) begin
            wd_d = wd_q + 1'b1;
        end else begin
            wd_d = wd_q;
        end
`endif
        req_d  = (state_d == REQ_HI);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            valid_q <= IDX_VALID;
            req_q   <= req_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef AER_TX_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end

    assign TIMEOUT_ERR = to_q;
`else
    assign TIMEOUT_ERR = 1'b0;
`endif

    assign AERIN_ADDR      = addr_q;
    assign AERIN_REQ       = req_q;
    assign AERIN_CTRL_BUSY = busy_q;
    assign EVT_SENT_CNT    = cnt_q;
    assign OVERRUN         = ovr_q;

endmodule

// File: tb/tb_aer_tx_link.sv
// Directed bench for aer_tx_link with an ACK responder model.
// The watchdog section runs only when AER_TX_TIMEOUT_EN is defined.
module tb_aer_tx_link;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [9:0]  IDX_IN = '0;
    logic        IDX_VALID = 1'b0;
    logic        ACK = 1'b0;
    logic [9:0]  ADDR;
    logic        REQ;
    logic        BUSY;
    logic [15:0] CNT;
    logic        OVR;
    logic        TO;

    logic [9:0]  addr2;
    logic        req2;
    logic        busy2;
    logic [1:0]  cnt2;
    logic        ovr2;
    logic        to2;

    int          checks = 0;
    int          errors = 0;
    bit          ack_en = 1'b1;
    logic        req_prev = 1'b0;
    logic [9:0]  last_addr = '0;
    int          pulses = 0;
    int          exp_cnt = 0;

    typedef struct {
        logic [9:0] idx;
        int         hold;
    } vec_t;

    vec_t vecs[6];

    aer_tx_link #(
        .AER_W(10), .SYNC_STAGES(2), .CNT_W(16), .TIMEOUT_CYCLES(15)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .IDX_IN(IDX_IN), .IDX_VALID(IDX_VALID),
        .AERIN_ADDR(ADDR), .AERIN_REQ(REQ), .AERIN_ACK(ACK),
        .AERIN_CTRL_BUSY(BUSY), .EVT_SENT_CNT(CNT), .OVERRUN(OVR),
        .TIMEOUT_ERR(TO)
    );

    aer_tx_link #(
        .AER_W(10), .SYNC_STAGES(2), .CNT_W(2), .TIMEOUT_CYCLES(15)
    ) dut_wrap (
        .CLK(CLK), .RST_N(RST_N), .IDX_IN(IDX_IN), .IDX_VALID(IDX_VALID),
        .AERIN_ADDR(addr2), .AERIN_REQ(req2), .AERIN_ACK(ACK),
        .AERIN_CTRL_BUSY(busy2), .EVT_SENT_CNT(cnt2), .OVERRUN(ovr2),
        .TIMEOUT_ERR(to2)
    );

    always #5 CLK = ~CLK;

    // Receiver: follows REQ about 3 cycles after each REQ edge
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (ack_en && REQ != ACK) begin
                repeat (2) @(posedge CLK);
                #1 ACK = REQ;
            end
        end
    end

    always @(negedge CLK) begin
        if (REQ && !req_prev) begin
            last_addr = ADDR;
            pulses++;
        end
        req_prev = REQ;
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (BUSY && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (BUSY) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout actual=1 required=0");
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (!REQ && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (!REQ) begin
            checks++;
            errors++;
            $display("FAIL req_timeout actual=0 required=1");
        end
    endtask

    task automatic send(logic [9:0] v, int hold);
        @(posedge CLK);
        #1;
        IDX_IN = v;
        IDX_VALID = 1'b1;
        @(posedge CLK);
        #1;
        chk("busy_t1", BUSY, 1);
        repeat (hold - 1) @(posedge CLK);
        #1 IDX_VALID = 1'b0;
    endtask

    initial begin
        int p0;
        int n;
        vecs[0] = '{10'h1FF, 2};
        vecs[1] = '{10'h1FF, 2};
        vecs[2] = '{10'h1FF, 3};
        vecs[3] = '{10'h003, 2};
        vecs[4] = '{10'h0A7, 2};
        vecs[5] = '{10'h000, 4};

        #12;
        chk("rst_addr", ADDR, 0);
        chk("rst_req", REQ, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_cnt", CNT, 0);
        chk("rst_ovr", OVR, 0);
        chk("rst_to", TO, 0);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < 6; i++) begin
            p0 = pulses;
            send(vecs[i].idx, vecs[i].hold);
            wait_idle();
            exp_cnt++;
            chk("vec_pulses", pulses - p0, 1);
            chk("vec_addr", last_addr, vecs[i].idx);
            chk("vec_cnt", CNT, exp_cnt);
            chk("vec_ovr", OVR, 0);
        end

        // Overrun while 0x012 is in flight
        p0 = pulses;
        send(10'h012, 2);
        wait_req();
        @(posedge CLK);
        #1;
        IDX_IN = 10'h055;
        IDX_VALID = 1'b1;
        repeat (2) @(posedge CLK);
        #1 IDX_VALID = 1'b0;
        wait_idle();
        exp_cnt++;
        chk("ovr_pulses", pulses - p0, 1);
        chk("ovr_addr", last_addr, 10'h012);
        chk("ovr_cnt", CNT, exp_cnt);
        chk("ovr_set", OVR, 1);
        send(10'h0A7, 2);
        wait_idle();
        exp_cnt++;
        chk("ovr_sticky", OVR, 1);
        chk("ovr_cnt2", CNT, exp_cnt);

        // ACK stuck high when 0x10A is captured
        ack_en = 1'b0;
        ACK = 1'b1;
        repeat (4) @(posedge CLK);
        send(10'h10A, 2);
        repeat (8) @(posedge CLK);
        #1;
        chk("stuck_req", REQ, 0);
        chk("stuck_busy", BUSY, 1);
        ACK = 1'b0;
        ack_en = 1'b1;
        n = 0;
        while (!REQ && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("stuck_lat", n, 3);
        wait_idle();
        exp_cnt++;
        chk("stuck_addr", last_addr, 10'h10A);
        chk("stuck_cnt", CNT, exp_cnt);
        chk("wrap_cnt", cnt2, exp_cnt % 4);

        // Reset during REQ_HI
        ack_en = 1'b0;
        send(10'h020, 2);
        wait_req();
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("mrst_req", REQ, 0);
        chk("mrst_busy", BUSY, 0);
        chk("mrst_cnt", CNT, 0);
        chk("mrst_ovr", OVR, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        ack_en = 1'b1;
        p0 = pulses;
        send(10'h020, 2);
        wait_idle();
        chk("mrst_pulses", pulses - p0, 1);
        chk("mrst_addr", last_addr, 10'h020);
        chk("mrst_cnt2", CNT, 1);

`ifdef AER_TX_TIMEOUT_EN
        ack_en = 1'b0;
        send(10'h3C3, 2);
        wait_req();
        @(posedge CLK);
        #1;
        n = 1;
        while (REQ && n < 100) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("to_lat", n, 15);
        chk("to_err", TO, 1);
        chk("to_busy", BUSY, 0);
        chk("to_cnt", CNT, 1);
`else
        chk("to_tied", TO, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aer_tx_link.md
Name: aer_tx_link

Overview:
- Downstream neighbour of the ROC encoder. Captures each 10-bit sorted pixel index the encoder presents and drives it off-chip or onto the accelerator AER input bus using a 4-phase REQ/ACK handshake.
- Returns a BUSY flag that throttles the encoder's WAIT_AER state.
- Passes the encoder's two leading 0x1FF AER-reset words like any other word, with no special handling.

Parameters:
- AER_W, 10, AER address width.
- SYNC_STAGES, 2, number of flip-flop stages synchronising the asynchronous AERIN_ACK (2 or more).
- CNT_W, 16, width of the sent-event counter.
- TIMEOUT_CYCLES, 1023, ACK watchdog limit (used only with the optional feature).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset; asynchronous assert, active-low.
- IDX_IN  in  AER_W  index from the encoder (its NEXT_INDEX).
- IDX_VALID  in  1  encoder's FOUND_NEXT_INDEX; may stay high for 2 or more cycles per word.
- AERIN_ADDR  out  AER_W  AER address bus.
- AERIN_REQ  out  1  AER request.
- AERIN_ACK  in  1  AER acknowledge; asynchronous, synchronised internally.
- AERIN_CTRL_BUSY  out  1  high while a word is captured or in flight.
- EVT_SENT_CNT  out  CNT_W  number of completed handshakes.
- OVERRUN  out  1  sticky; a word arrived while busy and was dropped.
- TIMEOUT_ERR  out  1  sticky watchdog flag; tied 0 when the optional feature is off.

Behaviour:
- Reset values (all asynchronous, RST_N low): AERIN_ADDR=0, AERIN_REQ=0, AERIN_CTRL_BUSY=0, EVT_SENT_CNT=0, OVERRUN=0, TIMEOUT_ERR=0, state=IDLE, synchroniser cleared.
- Capture is on the IDX_VALID rising edge only: valid_q is a registered copy of IDX_VALID; a word is taken when IDX_VALID & ~valid_q. Holding IDX_VALID high for 2 cycles yields exactly one word.
- Capture timing: on the capture edge (end of cycle t), IDX_IN is latched into addr_r and state goes IDLE→SETUP. AERIN_CTRL_BUSY is registered and is high from cycle t+1. The encoder samples BUSY in WAIT_AER at t+2 or later, so it always sees 1.
- FSM:
  - IDLE: wait for the capture edge.
  - SETUP: AERIN_ADDR=addr_r, AERIN_REQ=0; stay until ack_s==0 (covers ACK stuck high from a previous transfer). Minimum 1 cycle, so the address is valid at least 1 cycle before REQ.
  - REQ_HI: AERIN_REQ=1; stay until ack_s==1.
  - REQ_LO: AERIN_REQ=0; stay until ack_s==0. On exit, EVT_SENT_CNT+1, then go to IDLE.
- AERIN_ADDR holds its last value in IDLE. AERIN_REQ is a registered output with no combinational path from ACK.
- AERIN_CTRL_BUSY = (state != IDLE). It drops the cycle after REQ_LO exits.
- Minimum word period: 1 capture + 1 SETUP + SYNC_STAGES + 1 (REQ_HI) + SYNC_STAGES + 1 (REQ_LO) cycles.
- Capture edge while state != IDLE: word dropped, OVERRUN set to 1 (sticky until reset). The in-flight word is unaffected.
- EVT_SENT_CNT wraps 2^CNT_W-1 → 0 and raises no flag.
- Reset mid-handshake: REQ drops immediately and asynchronously. The word is lost, the counter is cleared, and the external receiver must tolerate REQ falling.
- IDX_VALID rising in the same cycle that REQ_LO exits: state≠IDLE in that cycle, so the word is dropped and OVERRUN is set. The encoder protocol prevents this case.

Optional Feature:
- Macro: AER_TX_TIMEOUT_EN.
- Defined: a watchdog counter clears on each state change and increments in REQ_HI and REQ_LO. When it reaches TIMEOUT_CYCLES:
  - REQ is forced 0;
  - TIMEOUT_ERR (sticky) is set to 1;
  - state goes to IDLE and EVT_SENT_CNT is not incremented.
- Undefined: no counter logic; TIMEOUT_ERR is tied 0; the handshake waits indefinitely.

Decomposition:
- Package aer_pkg:
  - aer_tx_state_t enum (IDLE, SETUP, REQ_HI, REQ_LO);
  - localparam AER_ADDR_W=10;
  - localparam AER_RST_WORD=10'h1FF.
- Sub-module sync_ff: parameterised SYNC_STAGES-deep synchroniser with active-low asynchronous reset, used for AERIN_ACK.

Test Plan:
- Single word: IDX_IN=0x1FF, IDX_VALID high 2 cycles; an ACK model responds 3 cycles after each REQ edge → one REQ pulse, AERIN_ADDR=0x1FF, EVT_SENT_CNT=1, BUSY high from t+1 until after ACK falls.
- Encoder-style sequence: 0x1FF, 0x1FF, then 0x003, 0x0A7, 0x000, each presented only after BUSY=0 → 5 handshakes in order, OVERRUN=0, EVT_SENT_CNT=5.
- Overrun: second IDX_VALID rising edge (0x055) while in REQ_HI with 0x012 → 0x012 completes, 0x055 never appears, OVERRUN=1 and stays 1.
- ACK held high at capture: AERIN_ACK=1 before the word 0x10A → REQ stays 0 in SETUP until ACK is low for SYNC_STAGES cycles, then a normal handshake.
- Reset mid-handshake: RST_N low during REQ_HI → REQ=0 and BUSY=0 in the same cycle, EVT_SENT_CNT=0; the next word 0x020 after release completes normally.
- With AER_TX_TIMEOUT_EN and TIMEOUT_CYCLES=15: never assert ACK after REQ → REQ falls 15 cycles after REQ_HI entry, TIMEOUT_ERR=1, BUSY=0, EVT_SENT_CNT unchanged.
